// File: rtl/mdu_seq.sv
// mdu_seq: iterative shift-add multiplier / restoring divider, WIDTH+1 cycle latency.
// Optional two's-complement mode is enabled by defining MDU_SIGNED_EN.  Rev 1.0
`default_nettype none

module mdu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       ALUop,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] sr,
   input  logic [WIDTH-1:0] tg,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result1,
   output logic [WIDTH-1:0] result2,
   output logic             DZ
);

   localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic                 init_q, init_d;
   logic                 dzp_q, dzp_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 is_div_q, is_div_d;
   logic [WIDTH-1:0]     sr_q, sr_d;
   logic [WIDTH-1:0]     tg_q, tg_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     op_b_q, op_b_d;
   logic [WIDTH:0]       rem_q, rem_d;
   logic [WIDTH-1:0]     result1_q, result1_d;
   logic [WIDTH-1:0]     result2_q, result2_d;
   logic                 dz_q, dz_d;

   logic                 accept;
   logic [WIDTH-1:0]     abs_sr, abs_tg;
   logic [WIDTH:0]       sum, shifted, trial;
   logic [2*WIDTH-1:0]   prod_nx, p_fix;
   logic [WIDTH-1:0]     q_nx, q_fix, r_fix;
   logic [WIDTH:0]       rem_nx;

   assign accept = start && (ALUop == 4'd3 || ALUop == 4'd4) && (state_q != RUN) && !dzp_q;

`ifdef MDU_SIGNED_EN
   logic signed_q;
   logic sr_neg, tg_neg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      signed_q <= 1'b0;
      else if (accept) signed_q <= signed_op;
   end

   assign sr_neg = signed_q & sr_q[WIDTH-1];
   assign tg_neg = signed_q & tg_q[WIDTH-1];
   assign abs_sr = sr_neg ? -sr_q : sr_q;
   assign abs_tg = tg_neg ? -tg_q : tg_q;
`else
   logic unused_signed_op;
   assign unused_signed_op = signed_op;
   assign abs_sr = sr_q;
   assign abs_tg = tg_q;
`endif

   // Multiply step: add multiplicand into the high half when the current multiplier bit is set.
   assign sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, op_b_q} : '0);
   assign prod_nx = {sum, acc_q[WIDTH-1:1]};

   // Divide step: a set MSB of the trial difference means it went negative, so restore.
   assign shifted = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
   assign trial   = shifted - {1'b0, op_b_q};
   assign q_nx    = {acc_q[WIDTH-2:0], ~trial[WIDTH]};
   assign rem_nx  = trial[WIDTH] ? shifted : trial;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         init_q    <= 1'b0;
         dzp_q     <= 1'b0;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         sr_q      <= '0;
         tg_q      <= '0;
         acc_q     <= '0;
         op_b_q    <= '0;
         rem_q     <= '0;
         result1_q <= '0;
         result2_q <= '0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         init_q    <= init_d;
         dzp_q     <= dzp_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         sr_q      <= sr_d;
         tg_q      <= tg_d;
         acc_q     <= acc_d;
         op_b_q    <= op_b_d;
         rem_q     <= rem_d;
         result1_q <= result1_d;
         result2_q <= result2_d;
         dz_q      <= dz_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      init_d    = init_q;
      dzp_d     = dzp_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      sr_d      = sr_q;
      tg_d      = tg_q;
      acc_d     = acc_q;
      op_b_d    = op_b_q;
      rem_d     = rem_q;
      result1_d = result1_q;
      result2_d = result2_q;
      dz_d      = dz_q;
      p_fix     = prod_nx;
      q_fix     = q_nx;
      r_fix     = rem_nx[WIDTH-1:0];
`ifdef MDU_SIGNED_EN
      if (sr_neg ^ tg_neg) begin
         p_fix = -prod_nx;
         q_fix = -q_nx;
      end
      if (sr_neg) r_fix = -rem_nx[WIDTH-1:0];
`endif

      case (state_q)
         RUN: begin
            if (init_q) begin
               // Conditioning cycle: load magnitudes before the first iteration.
               init_d = 1'b0;
               rem_d  = '0;
               if (is_div_q) begin
                  acc_d  = {{WIDTH{1'b0}}, abs_sr};
                  op_b_d = abs_tg;
               end else begin
                  acc_d  = {{WIDTH{1'b0}}, abs_tg};
                  op_b_d = abs_sr;
               end
            end else begin
               if (is_div_q) begin
                  acc_d[WIDTH-1:0] = q_nx;
                  rem_d            = rem_nx;
               end else begin
                  acc_d = prod_nx;
               end
               if (cnt_q == CNT_LAST) begin
                  state_d   = DONE;
                  result1_d = is_div_q ? q_fix : p_fix[WIDTH-1:0];
                  result2_d = is_div_q ? r_fix : p_fix[2*WIDTH-1:WIDTH];
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            if (dzp_q) begin
               dzp_d     = 1'b0;
               state_d   = DONE;
               result1_d = '1;
               result2_d = sr_q;
               dz_d      = 1'b1;
            end else if (accept) begin
               sr_d     = sr;
               tg_d     = tg;
               is_div_d = (ALUop == 4'd4);
               dz_d     = 1'b0;
               cnt_d    = '0;
               // Zero divisor waits one non-busy cycle in IDLE, then reports DONE.
               if (ALUop == 4'd4 && tg == '0) begin
                  dzp_d = 1'b1;
               end else begin
                  state_d = RUN;
                  init_d  = 1'b1;
               end
            end
         end
      endcase
   end

   assign busy    = (state_q == RUN);
   assign done    = (state_q == DONE);
   assign result1 = result1_q;
   assign result2 = result2_q;
   assign DZ      = dz_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: randomized self-checking bench for mdu_seq against an arithmetic reference model.
`default_nettype none

module tb_mdu_seq;
   localparam int W = 32;
`ifdef MDU_SIGNED_EN
   localparam bit SEN = 1'b1;
`else
   localparam bit SEN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [3:0]   ALUop = 4'd0;
   logic         signed_op = 1'b0;
   logic [W-1:0] sr = '0;
   logic [W-1:0] tg = '0;
   logic         busy, done, DZ;
   logic [W-1:0] result1, result2;

   int n_chk  = 0;
   int n_pass = 0;

   mdu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ALUop(ALUop), .signed_op(signed_op),
      .sr(sr), .tg(tg), .busy(busy), .done(done), .result1(result1), .result2(result2), .DZ(DZ)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
      $fatal(1);
   end

   // Reference: plain arithmetic on the full-width values.
   function automatic void model(input logic [3:0] op, input bit sgn, input logic [W-1:0] a,
                                 input logic [W-1:0] b, output logic [W-1:0] r1,
                                 output logic [W-1:0] r2, output logic dz);
      longint      sa, sb, p, q, r;
      logic [63:0] up;
      dz = 1'b0;
      if (op == 4'd4 && b == '0) begin
         r1 = '1; r2 = a; dz = 1'b1;
      end else if (sgn && SEN) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         if (op == 4'd3) begin
            p = sa * sb; r1 = p[31:0]; r2 = p[63:32];
         end else begin
            q = sa / sb; r = sa % sb; r1 = q[31:0]; r2 = r[31:0];
         end
      end else if (op == 4'd3) begin
         up = {32'd0, a} * {32'd0, b}; r1 = up[31:0]; r2 = up[63:32];
      end else begin
         r1 = a / b; r2 = a % b;
      end
   endfunction

   // Issue one request, scramble inputs after acceptance, and measure edges until done.
   task automatic do_op(input logic [3:0] op, input bit sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int lat, output int busy_n, output bit overlap);
      @(negedge clk);
      start = 1'b1; ALUop = op; signed_op = sgn; sr = a; tg = b;
      @(negedge clk);
      start = 1'b0; ALUop = 4'd0; sr = $urandom; tg = $urandom; signed_op = ~sgn;
      lat = 0; busy_n = 0; overlap = 1'b0;
      while (!done && lat < 100) begin
         if (busy) busy_n++;
         @(negedge clk);
         lat++;
      end
      if (busy && done) overlap = 1'b1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b need 0", busy); else n_pass++;
      n_chk++; if (done !== 1'b0) $display("FAIL reset_done: got %b need 0", done); else n_pass++;
      n_chk++; if (result1 !== '0) $display("FAIL reset_r1: got %h need 0", result1); else n_pass++;
      n_chk++; if (result2 !== '0) $display("FAIL reset_r2: got %h need 0", result2); else n_pass++;
      n_chk++; if (DZ !== 1'b0) $display("FAIL reset_dz: got %b need 0", DZ); else n_pass++;
      rst_n = 1'b1;
   endtask

   task automatic test_arith(input logic [3:0] op, input int n);
      logic [W-1:0] a, b, e1, e2;
      logic         edz;
      bit           sgn, ov;
      int           lat, bn;
      for (int i = 0; i < n; i++) begin
         sgn = 1'($urandom_range(0, 1));
         a = $urandom;
         b = ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(1, 1000));
         if (i == 0) begin sgn = 1'b0; a = 32'h10; b = (op == 4'd3) ? 32'h4 : 32'h3; end
         if (i == 1) begin sgn = 1'b0; a = 32'hFFFF_FFFF; b = (op == 4'd3) ? 32'hFFFF_FFFF : 32'h1; end
         model(op, sgn, a, b, e1, e2, edz);
         do_op(op, sgn, a, b, lat, bn, ov);
         n_chk++; if (lat !== 33) $display("FAIL op%0d_latency[%0d]: got %0d need 33", op, i, lat); else n_pass++;
         n_chk++; if (bn !== 33) $display("FAIL op%0d_busy_cycles[%0d]: got %0d need 33", op, i, bn); else n_pass++;
         n_chk++; if (ov !== 1'b0) $display("FAIL op%0d_busy_done_overlap[%0d]: got 1 need 0", op, i); else n_pass++;
         n_chk++; if (result1 !== e1) $display("FAIL op%0d_r1[%0d] a=%h b=%h s=%b: got %h need %h", op, i, a, b, sgn, result1, e1); else n_pass++;
         n_chk++; if (result2 !== e2) $display("FAIL op%0d_r2[%0d] a=%h b=%h s=%b: got %h need %h", op, i, a, b, sgn, result2, e2); else n_pass++;
         n_chk++; if (DZ !== edz) $display("FAIL op%0d_dz[%0d]: got %b need %b", op, i, DZ, edz); else n_pass++;
      end
   endtask

   task automatic test_div_zero();
      int lat, bn;
      bit ov;
      do_op(4'd4, 1'b0, 32'h1234, 32'h0, lat, bn, ov);
      n_chk++; if (lat !== 1) $display("FAIL dz_latency: got %0d need 1", lat); else n_pass++;
      n_chk++; if (bn !== 0) $display("FAIL dz_busy_cycles: got %0d need 0", bn); else n_pass++;
      n_chk++; if (result1 !== 32'hFFFF_FFFF) $display("FAIL dz_r1: got %h need ffffffff", result1); else n_pass++;
      n_chk++; if (result2 !== 32'h1234) $display("FAIL dz_r2: got %h need 00001234", result2); else n_pass++;
      n_chk++; if (DZ !== 1'b1) $display("FAIL dz_flag: got %b need 1", DZ); else n_pass++;
      repeat (3) @(negedge clk);
      n_chk++; if (DZ !== 1'b1) $display("FAIL dz_held: got %b need 1", DZ); else n_pass++;
      n_chk++; if (done !== 1'b0) $display("FAIL dz_done_pulse: got %b need 0", done); else n_pass++;
      do_op(4'd3, 1'b0, 32'd6, 32'd7, lat, bn, ov);
      n_chk++; if (DZ !== 1'b0) $display("FAIL dz_cleared: got %b need 0", DZ); else n_pass++;
      n_chk++; if (result1 !== 32'd42) $display("FAIL dz_followup_r1: got %h need 0000002a", result1); else n_pass++;
   endtask

`ifdef MDU_SIGNED_EN
   task automatic test_signed();
      logic [W-1:0] av [4] = '{32'hFFFF_FFFB, 32'hFFFF_FFF9, 32'h8000_0000, 32'h0000_0064};
      logic [W-1:0] bv [4] = '{32'h3, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
      logic [3:0]   ov4 [4] = '{4'd3, 4'd4, 4'd4, 4'd4};
      logic [W-1:0] x1 [4] = '{32'hFFFF_FFF1, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF2};
      logic [W-1:0] x2 [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h2};
      int lat, bn;
      bit ov;
      for (int i = 0; i < 4; i++) begin
         do_op(ov4[i], 1'b1, av[i], bv[i], lat, bn, ov);
         n_chk++; if (lat !== 33) $display("FAIL signed_latency[%0d]: got %0d need 33", i, lat); else n_pass++;
         n_chk++; if (result1 !== x1[i]) $display("FAIL signed_r1[%0d]: got %h need %h", i, result1, x1[i]); else n_pass++;
         n_chk++; if (result2 !== x2[i]) $display("FAIL signed_r2[%0d]: got %h need %h", i, result2, x2[i]); else n_pass++;
         n_chk++; if (DZ !== 1'b0) $display("FAIL signed_dz[%0d]: got %b need 0", i, DZ); else n_pass++;
      end
   endtask
`endif

   task automatic test_ignore_in_run();
      int lat;
      @(negedge clk);
      start = 1'b1; ALUop = 4'd3; signed_op = 1'b0; sr = 32'd1000; tg = 32'd3;
      @(negedge clk);
      start = 1'b0; ALUop = 4'd0;
      lat = 0;
      repeat (10) begin @(negedge clk); lat++; end
      start = 1'b1; ALUop = 4'd4; sr = 32'd77; tg = 32'd5;
      @(negedge clk);
      lat++;
      start = 1'b0; ALUop = 4'd0;
      while (!done && lat < 100) begin @(negedge clk); lat++; end
      n_chk++; if (lat !== 33) $display("FAIL run_ignore_latency: got %0d need 33", lat); else n_pass++;
      n_chk++; if (result1 !== 32'd3000) $display("FAIL run_ignore_r1: got %h need 00000bb8", result1); else n_pass++;
      n_chk++; if (result2 !== 32'd0) $display("FAIL run_ignore_r2: got %h need 0", result2); else n_pass++;
      @(negedge clk);
      n_chk++; if (busy !== 1'b0) $display("FAIL run_ignore_no_second: got busy %b need 0", busy); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int lat, bn;
      bit ov;
      do_op(4'd3, 1'b0, 32'd7, 32'd9, lat, bn, ov);
      n_chk++; if (result1 !== 32'd63) $display("FAIL b2b_first_r1: got %h need 0000003f", result1); else n_pass++;
      start = 1'b1; ALUop = 4'd4; signed_op = 1'b0; sr = 32'd100; tg = 32'd7;
      @(negedge clk);
      start = 1'b0; ALUop = 4'd0;
      n_chk++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b need 1", busy); else n_pass++;
      n_chk++; if (result1 !== 32'd63) $display("FAIL b2b_prev_visible: got %h need 0000003f", result1); else n_pass++;
      lat = 0;
      while (!done && lat < 100) begin @(negedge clk); lat++; end
      n_chk++; if (lat !== 33) $display("FAIL b2b_latency: got %0d need 33", lat); else n_pass++;
      n_chk++; if (result1 !== 32'd14) $display("FAIL b2b_r1: got %h need 0000000e", result1); else n_pass++;
      n_chk++; if (result2 !== 32'd2) $display("FAIL b2b_r2: got %h need 00000002", result2); else n_pass++;
   endtask

   task automatic test_bad_op();
      logic [3:0] ops [3] = '{4'd5, 4'd0, 4'd15};
      logic [W-1:0] keep;
      bit seen;
      keep = result1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start = 1'b1; ALUop = ops[i]; sr = $urandom; tg = 32'd0;
         @(negedge clk);
         start = 1'b0; ALUop = 4'd0;
         seen = 1'b0;
         repeat (4) begin
            if (busy || done) seen = 1'b1;
            @(negedge clk);
         end
         n_chk++; if (seen !== 1'b0) $display("FAIL bad_op%0d_activity: got 1 need 0", ops[i]); else n_pass++;
      end
      n_chk++; if (result1 !== keep) $display("FAIL bad_op_results_kept: got %h need %h", result1, keep); else n_pass++;
   endtask

   task automatic test_reset_mid_op();
      int lat, bn;
      bit ov, seen;
      @(negedge clk);
      start = 1'b1; ALUop = 4'd3; signed_op = 1'b0; sr = 32'h0001_0001; tg = 32'h0000_0100;
      @(negedge clk);
      start = 1'b0; ALUop = 4'd0;
      repeat (15) @(negedge clk);
      n_chk++; if (busy !== 1'b1) $display("FAIL rst_mid_pre_busy: got %b need 1", busy); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_chk++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b need 0", busy); else n_pass++;
      n_chk++; if (done !== 1'b0) $display("FAIL rst_mid_done: got %b need 0", done); else n_pass++;
      n_chk++; if (result1 !== '0) $display("FAIL rst_mid_r1: got %h need 0", result1); else n_pass++;
      n_chk++; if (result2 !== '0) $display("FAIL rst_mid_r2: got %h need 0", result2); else n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      n_chk++; if (seen !== 1'b0) $display("FAIL rst_mid_aborted_activity: got 1 need 0"); else n_pass++;
      do_op(4'd3, 1'b0, 32'h0001_0001, 32'h0000_0100, lat, bn, ov);
      n_chk++; if (lat !== 33) $display("FAIL rst_after_latency: got %0d need 33", lat); else n_pass++;
      n_chk++; if (result1 !== 32'h0100_0100) $display("FAIL rst_after_r1: got %h need 01000100", result1); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_arith(4'd3, 8);
      test_arith(4'd4, 8);
      test_div_zero();
`ifdef MDU_SIGNED_EN
      test_signed();
`endif
      test_ignore_in_run();
      test_back_to_back();
      test_bad_op();
      test_reset_mid_op();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mdu_seq.md
# mdu_seq

Iterative multi-cycle multiply/divide unit that executes the ALU's `ALUop` 3 (mul) and 4 (div) encodings sequentially instead of combinationally. It sits beside the ALU in the execute stage. It answers a one-cycle `start` request from the pipeline control (or a bench driver) with `busy`, then a one-cycle `done` pulse. It returns results on `result1`/`result2` using the same packing as the ALU: low product or quotient on `result1`, high product or remainder on `result2`.

## Interface
- `WIDTH`, 32: operand width; iteration count equals `WIDTH`.
- `clk` input 1: clock, rising-edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request strobe, sampled on rising edge.
- `ALUop` input 4: 3 = mul, 4 = div; any other value with `start` is ignored.
- `signed_op` input 1: 1 = two's-complement operands (only honoured with `MDU_SIGNED_EN`).
- `sr` input WIDTH: multiplicand / dividend.
- `tg` input WIDTH: multiplier / divisor.
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle pulse, results valid.
- `result1` output WIDTH: product[WIDTH-1:0] or quotient.
- `result2` output WIDTH: product[2*WIDTH-1:WIDTH] or remainder.
- `DZ` output 1: divide-by-zero flag, valid with `done`, held until the next accepted start.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: `busy`=0, `done`=0, `result1`=0, `result2`=0, `DZ`=0. The counter and operand registers are cleared.
- Accept condition: `start`=1, `ALUop` is 3 or 4, and the state is IDLE or DONE. On accept the block latches `sr`, `tg`, `ALUop` and `signed_op`, clears `DZ`, and enters RUN with counter=0.
- While in RUN, `start` is ignored and the latched operands are unaffected by input changes.
- Mul: radix-2 shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle.
- Div: restoring division, one quotient bit per cycle. The remainder register is WIDTH+1 bits to hold the trial subtraction.
- The counter runs 0..WIDTH-1. At WIDTH-1 the block writes the results and goes RUN→DONE.
- DONE lasts exactly one cycle, then returns to IDLE unless a new start is accepted in that cycle.
- Div with `tg`=0: the block skips RUN and goes IDLE→DONE. It sets `result1`=all ones, `result2`=latched `sr`, `DZ`=1.
- `result1`/`result2` hold their values from DONE until the next DONE. They do not change during RUN.
- Signed mode operates on absolute values and applies the sign fix when results are written:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
- Signed 0x80000000 / 0xFFFFFFFF gives `result1`=0x80000000, `result2`=0. No trap, `DZ`=0.

## Timing
- Start sampled at edge E:
  - `busy`=1 from E to E+WIDTH.
  - `done`=1 and results valid during the cycle after edge E+WIDTH+1.
  - Latency is WIDTH+1 = 33 edges.
- Divide-by-zero: `done`=1 after edge E+1. `busy` never asserts.
- `busy` and `done` are never both 1.
- Back-to-back: a start accepted during the DONE cycle makes `busy`=1 after the next edge. There is no idle bubble, and the previous results stay visible until the new DONE.
- Asserting `rst_n`=0 mid-RUN immediately forces all outputs to their reset values. After release the block is in IDLE, and the aborted operation never produces `done`.

## Configuration
- `MDU_SIGNED_EN` defined: `signed_op` selects signed mode as described above.
- `MDU_SIGNED_EN` undefined:
  - `signed_op` is ignored and all operations are unsigned.
  - The sign-fix logic is not compiled.
  - Latency is unchanged.

## Test plan
- Unsigned mul: `ALUop`=3, `sr`=0x10, `tg`=0x4 → `done` 33 edges after start; `result1`=0x40, `result2`=0, `DZ`=0.
- Unsigned div: `ALUop`=4, `sr`=0x10, `tg`=0x3 → `result1`=5, `result2`=1. Also `sr`=0xFFFFFFFF, `tg`=1 → `result1`=0xFFFFFFFF, `result2`=0.
- Divide by zero: `sr`=0x1234, `tg`=0 → `done` one edge after start, `busy` stays 0; `result1`=0xFFFFFFFF, `result2`=0x1234, `DZ`=1.
- Signed (`MDU_SIGNED_EN`, `signed_op`=1):
  - -5 × 3 → `result1`=0xFFFFFFF1, `result2`=0xFFFFFFFF.
  - -7 / 2 → `result1`=0xFFFFFFFD, `result2`=0xFFFFFFFF.
- Handshake:
  - A start with changed operands at cycle 10 of RUN → ignored, and the original result is returned.
  - A start during DONE → accepted back-to-back.
  - A start with `ALUop`=5 → no `busy`.
- Reset mid-op: drop `rst_n` at RUN cycle 15 → `busy`, `done`, `result1`, `result2` are 0 immediately. A fresh mul after release completes correctly.
